// File: rtl/goertzel_frame_ctrl_if.sv
// Control/status bundle between the frame sequencer, the SPI register file,
// the CORDIC coefficient engine and the Goertzel bin bank.
interface goertzel_frame_ctrl_if #(
    parameter int unsigned NF    = 11,
    parameter int unsigned CNT_W = 17
);
    logic             start;
    logic             abort;
    logic             sts_clr;
    logic             cordic_start;
    logic             cordic_done;
    logic             smp_valid;
    logic             bin_clear;
    logic             bin_en;
    logic             bin_last;
    logic [NF-1:0]    bin_valid;
    logic             busy;
    logic             done;
    logic             err_tmo;
    logic [CNT_W-1:0] smp_cnt;

    modport master (
        output start, abort, sts_clr, cordic_done, smp_valid, bin_valid,
        input  cordic_start, bin_clear, bin_en, bin_last, busy, done, err_tmo, smp_cnt
    );

    modport slave (
        input  start, abort, sts_clr, cordic_done, smp_valid, bin_valid,
        output cordic_start, bin_clear, bin_en, bin_last, busy, done, err_tmo, smp_cnt
    );
endinterface

// File: rtl/goertzel_frame_ctrl.sv
// Frame sequencer for the Goertzel bin bank: CORDIC coefficient load, bin clear,
// NS-sample accumulation window and result flush with sticky done/timeout status.
module goertzel_frame_ctrl #(
    parameter int unsigned NF      = 11,
    parameter int unsigned NS      = 100000,
    parameter int unsigned TMO_CYC = 4096
) (
    input logic                  clk,
    input logic                  rst,
    goertzel_frame_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(NS + 1);
    localparam int unsigned TMO_W = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    typedef enum logic [2:0] {IDLE, COEF, CLR, ACCUM, FLUSH} state_t;

    state_t           state_q;
    logic [TMO_W-1:0] tmo_q;
    logic [CNT_W-1:0] smp_cnt_q;
    logic             cordic_start_q;
    logic             bin_clear_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [NF-1:0]    bin_valid;
    logic             all_valid;
    logic             accept;

    assign bin_valid = bus.bin_valid;
    assign all_valid = &bin_valid;

    // Sample gate is combinational so the bank sees the strobe in the same cycle.
    assign accept = (state_q == ACCUM) && bus.smp_valid && !bus.abort && !rst;

    assign bus.bin_en       = accept;
    assign bus.bin_last     = accept && (smp_cnt_q == CNT_LAST);
    assign bus.cordic_start = cordic_start_q;
    assign bus.bin_clear    = bin_clear_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err_tmo      = err_q;
    assign bus.smp_cnt      = smp_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            tmo_q          <= '0;
            smp_cnt_q      <= '0;
            cordic_start_q <= 1'b0;
            bin_clear_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            cordic_start_q <= 1'b0;
            bin_clear_q    <= 1'b0;
            // Flag sets below are later in the block, so they win over sts_clr.
            if (bus.sts_clr) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if ((state_q != IDLE) && bus.abort) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                tmo_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            state_q        <= COEF;
                            busy_q         <= 1'b1;
                            cordic_start_q <= 1'b1;
                            done_q         <= 1'b0;
                            err_q          <= 1'b0;
                            smp_cnt_q      <= '0;
                            tmo_q          <= '0;
                        end
                    end
                    COEF: begin
                        if (bus.cordic_done) begin
                            state_q     <= CLR;
                            bin_clear_q <= 1'b1;
                            tmo_q       <= '0;
                        end else if (tmo_q == TMO_LAST) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                            tmo_q   <= '0;
                        end else begin
                            tmo_q <= tmo_q + TMO_W'(1);
                        end
                    end
                    CLR: begin
                        state_q <= ACCUM;
                    end
                    ACCUM: begin
                        if (bus.smp_valid) begin
                            if (smp_cnt_q == CNT_LAST) begin
                                smp_cnt_q <= CNT_FULL;
                                state_q   <= FLUSH;
                                tmo_q     <= '0;
                            end else if (smp_cnt_q != CNT_FULL) begin
                                smp_cnt_q <= smp_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    FLUSH: begin
                        if (all_valid) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            tmo_q   <= '0;
                        end else if (tmo_q == TMO_LAST) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                            tmo_q   <= '0;
                        end else begin
                            tmo_q <= tmo_q + TMO_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        tmo_q   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_goertzel_frame_ctrl.sv
// Directed bench for goertzel_frame_ctrl with a transaction-level frame model
// checked every cycle, plus hand-computed expectations per scenario.
module tb_goertzel_frame_ctrl;
    localparam int NF      = 3;
    localparam int NS      = 8;
    localparam int TMO_CYC = 16;
    localparam int CNT_W   = 4;

    localparam int P_IDLE  = 0;
    localparam int P_COEF  = 1;
    localparam int P_CLR   = 2;
    localparam int P_ACCUM = 3;
    localparam int P_FLUSH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    goertzel_frame_ctrl_if #(.NF(NF), .CNT_W(CNT_W)) bus ();

    goertzel_frame_ctrl #(.NF(NF), .NS(NS), .TMO_CYC(TMO_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ph;
        int cnt;
        int age;
        bit done;
        bit err;
        bit cst;
        bit bclr;
    } mdl_t;

    mdl_t mdl;
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;
    int   n_en, n_clr, n_last, last_idx;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.ph = P_IDLE; r.cnt = 0; r.age = 0;
        r.done = 1'b0; r.err = 1'b0; r.cst = 1'b0; r.bclr = 1'b0;
        return r;
    endfunction

    // Frame-level rules: what one clock edge does to the visible status.
    function automatic mdl_t step(mdl_t m, bit st, bit ab, bit clr, bit cd, bit sv,
                                  logic [NF-1:0] bv);
        mdl_t n = m;
        n.cst  = 1'b0;
        n.bclr = 1'b0;
        if (clr) begin
            n.done = 1'b0;
            n.err  = 1'b0;
        end
        if (m.ph == P_IDLE) begin
            if (st) begin
                n.ph = P_COEF; n.cst = 1'b1; n.done = 1'b0; n.err = 1'b0; n.cnt = 0;
            end
        end else if (ab) begin
            n.ph = P_IDLE;
        end else if (m.ph == P_COEF) begin
            if (cd) begin
                n.ph = P_CLR; n.bclr = 1'b1;
            end else if (m.age >= TMO_CYC - 1) begin
                n.ph = P_IDLE; n.err = 1'b1;
            end
        end else if (m.ph == P_CLR) begin
            n.ph = P_ACCUM;
        end else if (m.ph == P_ACCUM) begin
            if (sv) begin
                n.cnt = (m.cnt + 1 > NS) ? NS : m.cnt + 1;
                if (n.cnt == NS) n.ph = P_FLUSH;
            end
        end else begin
            if (bv == 3'b111) begin
                n.ph = P_IDLE; n.done = 1'b1;
            end else if (m.age >= TMO_CYC - 1) begin
                n.ph = P_IDLE; n.err = 1'b1;
            end
        end
        n.age = (n.ph != m.ph || n.ph == P_IDLE) ? 0 : m.age + 1;
        return n;
    endfunction

    function automatic logic [10:0] expect_vec(mdl_t m);
        bit en;
        en = (m.ph == P_ACCUM) && bus.smp_valid && !bus.abort && !rst;
        return {m.cst, m.bclr, en, en && (m.cnt == NS - 1), (m.ph != P_IDLE),
                m.done, m.err, 4'(m.cnt)};
    endfunction

    function automatic logic [10:0] actual_vec();
        return {bus.cordic_start, bus.bin_clear, bus.bin_en, bus.bin_last, bus.busy,
                bus.done, bus.err_tmo, bus.smp_cnt};
    endfunction

    // One clock: compare at negedge, advance the model, then drive after posedge.
    task automatic tick();
        logic [10:0] e, a;
        @(negedge clk);
        if (chk_en) begin
            e = expect_vec(mdl);
            a = actual_vec();
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL cycle_model t=%0t actual=%b required=%b", $time, a, e);
            end
            if (bus.bin_en === 1'b1) n_en++;
            if (bus.bin_clear === 1'b1) n_clr++;
            if (bus.bin_last === 1'b1) begin
                n_last++;
                last_idx = n_en;
            end
        end
        if (rst) mdl = mdl_reset();
        else mdl = step(mdl, bus.start, bus.abort, bus.sts_clr, bus.cordic_done,
                        bus.smp_valid, bus.bin_valid);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic clr_counts();
        n_en = 0; n_clr = 0; n_last = 0; last_idx = 0;
    endtask

    // start -> COEF, immediate cordic_done -> CLR -> first ACCUM cycle
    task automatic enter_accum();
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        bus.cordic_done = 1'b1; tick(); bus.cordic_done = 1'b0;
        tick();
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.sts_clr = 1'b0;
        bus.cordic_done = 1'b0; bus.smp_valid = 1'b0; bus.bin_valid = '0;
        clr_counts();
        mdl = mdl_reset();
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_smp_cnt", int'(bus.smp_cnt), 0);

        // Nominal frame, samples on every 2nd cycle
        clr_counts();
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        chk("nom_cordic_start", int'(bus.cordic_start), 1);
        repeat (4) tick();
        bus.cordic_done = 1'b1; tick(); bus.cordic_done = 1'b0;
        chk("nom_bin_clear", int'(bus.bin_clear), 1);
        tick();
        for (int i = 0; i < 16; i++) begin
            bus.smp_valid = (i % 2 == 0);
            tick();
        end
        bus.smp_valid = 1'b0;
        tick();
        bus.bin_valid = 3'b111; tick(); bus.bin_valid = '0;
        chk("nom_done", int'(bus.done), 1);
        chk("nom_err", int'(bus.err_tmo), 0);
        chk("nom_busy", int'(bus.busy), 0);
        chk("nom_smp_cnt", int'(bus.smp_cnt), 8);
        chk("nom_en_pulses", n_en, 8);
        chk("nom_clr_pulses", n_clr, 1);
        chk("nom_last_pulses", n_last, 1);
        chk("nom_last_on_8th", last_idx, 8);

        // COEF timeout
        clr_counts();
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        repeat (15) tick();
        chk("coef_busy_c15", int'(bus.busy), 1);
        chk("coef_err_c15", int'(bus.err_tmo), 0);
        tick();
        chk("coef_busy_c16", int'(bus.busy), 0);
        chk("coef_err_c16", int'(bus.err_tmo), 1);
        chk("coef_no_clear", n_clr, 0);
        bus.sts_clr = 1'b1; tick(); bus.sts_clr = 1'b0;
        chk("stsclr_err", int'(bus.err_tmo), 0);

        // Back-to-back samples then FLUSH timeout
        clr_counts();
        enter_accum();
        bus.smp_valid = 1'b1;
        repeat (8) tick();
        chk("b2b_en_pulses", n_en, 8);
        chk("b2b_smp_cnt", int'(bus.smp_cnt), 8);
        bus.bin_valid = 3'b101;
        repeat (15) tick();
        chk("flush_busy_c15", int'(bus.busy), 1);
        tick();
        chk("flush_busy_c16", int'(bus.busy), 0);
        chk("flush_err", int'(bus.err_tmo), 1);
        chk("flush_done", int'(bus.done), 0);
        chk("flush_no_extra_en", n_en, 8);
        bus.smp_valid = 1'b0; bus.bin_valid = '0;
        tick();

        // Abort after 4 samples
        clr_counts();
        enter_accum();
        bus.smp_valid = 1'b1;
        repeat (4) tick();
        chk("abort_cnt_before", int'(bus.smp_cnt), 4);
        bus.abort = 1'b1;
        #1;
        chk("abort_en_forced", int'(bus.bin_en), 0);
        tick(); bus.abort = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_smp_cnt", int'(bus.smp_cnt), 4);
        chk("abort_done", int'(bus.done), 0);
        repeat (3) tick();
        chk("abort_en_pulses", n_en, 4);
        bus.smp_valid = 1'b0;

        // start and abort together in IDLE: start wins
        bus.start = 1'b1; bus.abort = 1'b1; tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("startabort_busy", int'(bus.busy), 1);
        bus.abort = 1'b1; tick(); bus.abort = 1'b0;
        chk("abort_coef_busy", int'(bus.busy), 0);

        // start ignored while accumulating; done set wins over sts_clr
        clr_counts();
        enter_accum();
        bus.smp_valid = 1'b1;
        repeat (3) tick();
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        chk("busy_start_cnt", int'(bus.smp_cnt), 4);
        chk("busy_start_no_cstart", int'(bus.cordic_start), 0);
        repeat (4) tick();
        bus.smp_valid = 1'b0;
        bus.bin_valid = 3'b111; bus.sts_clr = 1'b1; tick();
        bus.bin_valid = '0; bus.sts_clr = 1'b0;
        chk("set_beats_clr_done", int'(bus.done), 1);
        bus.sts_clr = 1'b1; tick(); bus.sts_clr = 1'b0;
        chk("stsclr_done", int'(bus.done), 0);

        // rst while in FLUSH
        enter_accum();
        bus.smp_valid = 1'b1;
        repeat (8) tick();
        chk("pre_rst_busy", int'(bus.busy), 1);
        rst = 1'b1; tick();
        chk("rst_all_zero", int'(actual_vec()), 0);
        rst = 1'b0; bus.smp_valid = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
